// File: rtl/wl_sched_pkg.sv
// Shared types, default parameters and helpers for the wordline sweep scheduler.
package wl_sched_pkg;

    typedef enum logic [1:0] {S_IDLE, S_GRANT, S_DONE} state_e;

    localparam int unsigned N_PORTS_DEF   = 4;
    localparam int unsigned TO_W_DEF      = 8;
    localparam int unsigned TO_CYCLES_DEF = 200;

    function automatic int unsigned onehot_to_idx(input logic [31:0] oh);
        int unsigned idx;
        idx = 0;
        for (int i = 0; i < 32; i++) begin
            if (oh[i]) idx = i;
        end
        return idx;
    endfunction

endpackage

// File: rtl/wl_sweep_scheduler_if.sv
// Sweep initiator / shared-encoder handshake bundle for the sweep scheduler.
interface wl_sweep_scheduler_if #(
    parameter int unsigned N_PORTS = 4
);
    logic               start;
    logic [N_PORTS-1:0] wl_req;
    logic [N_PORTS-1:0] grant;
    logic               grant_valid;
    logic               grant_ack;
    logic               busy;
    logic               done;
    logic [N_PORTS-1:0] served_mask;
    logic               timeout_err;

    modport master (
        output start, wl_req, grant_ack,
        input  grant, grant_valid, busy, done, served_mask, timeout_err
    );

    modport slave (
        input  start, wl_req, grant_ack,
        output grant, grant_valid, busy, done, served_mask, timeout_err
    );
endinterface

// File: rtl/wl_rr_pick.sv
// Round-robin picker: lowest set bit at or above ptr, else wrap to the lowest set bit.
module wl_rr_pick
    import wl_sched_pkg::*;
#(
    parameter int unsigned N_PORTS = N_PORTS_DEF
) (
    input  logic [N_PORTS-1:0]         i_mask,
    input  logic [$clog2(N_PORTS)-1:0] i_ptr,
    output logic [N_PORTS-1:0]         o_onehot,
    output logic [$clog2(N_PORTS)-1:0] o_idx,
    output logic                       o_any
);
    localparam int unsigned IDX_W = $clog2(N_PORTS);

    logic [N_PORTS-1:0] w_hi_oh;
    logic [N_PORTS-1:0] w_lo_oh;
    logic [N_PORTS-1:0] w_oh;

    // Scan downward so the last hit in each half is its lowest index.
    always_comb begin
        w_hi_oh = '0;
        w_lo_oh = '0;
        for (int i = N_PORTS - 1; i >= 0; i--) begin
            if (i_mask[i]) begin
                if (i >= int'(i_ptr)) begin
                    w_hi_oh    = '0;
                    w_hi_oh[i] = 1'b1;
                end else begin
                    w_lo_oh    = '0;
                    w_lo_oh[i] = 1'b1;
                end
            end
        end
    end

    assign w_oh     = (|w_hi_oh) ? w_hi_oh : w_lo_oh;
    assign o_onehot = w_oh;
    assign o_any    = |i_mask;
    assign o_idx    = IDX_W'(onehot_to_idx(32'(w_oh)));

endmodule

// File: rtl/wl_sweep_scheduler.sv
// Grants each requester of a snapshotted vector in round-robin order, one at a time,
// with per-grant ack/timeout and a done pulse at the end of the sweep.
module wl_sweep_scheduler
    import wl_sched_pkg::*;
#(
    parameter int unsigned N_PORTS   = N_PORTS_DEF,
    parameter int unsigned TO_W      = TO_W_DEF,
    parameter int unsigned TO_CYCLES = TO_CYCLES_DEF
) (
    input logic                 i_clk,
    input logic                 i_rst,
    wl_sweep_scheduler_if.slave bus
);
    localparam int unsigned IDX_W = $clog2(N_PORTS);

    state_e             r_state;
    logic [N_PORTS-1:0] r_pending;
    logic [N_PORTS-1:0] r_served;
    logic [N_PORTS-1:0] r_grant;
    logic               r_grant_valid;
    logic               r_busy;
    logic               r_done;
    logic               r_terr;
    logic [IDX_W-1:0]   r_ptr;
    logic [IDX_W-1:0]   r_idx;
    logic [TO_W-1:0]    r_cnt;

    logic               w_ack;
    logic               w_retire;
    logic [N_PORTS-1:0] w_rem;
    logic [IDX_W-1:0]   w_next_ptr;
    logic [N_PORTS-1:0] w_pick_mask;
    logic [IDX_W-1:0]   w_pick_ptr;
    logic [N_PORTS-1:0] w_pick_oh;
    logic [IDX_W-1:0]   w_pick_idx;
    logic               w_pick_any;

    assign w_ack      = bus.grant_ack && r_grant_valid;
    assign w_retire   = w_ack || (r_cnt == TO_W'(TO_CYCLES - 1));
    assign w_rem      = r_pending & ~r_grant;
    assign w_next_ptr = (r_idx == IDX_W'(N_PORTS - 1)) ? '0 : r_idx + 1'b1;

    // One picker serves both the first grant (from the live request) and every follow-on.
    assign w_pick_mask = (r_state == S_IDLE) ? bus.wl_req : w_rem;
    assign w_pick_ptr  = (r_state == S_IDLE) ? r_ptr : w_next_ptr;

    wl_rr_pick #(
        .N_PORTS (N_PORTS)
    ) u_pick (
        .i_mask   (w_pick_mask),
        .i_ptr    (w_pick_ptr),
        .o_onehot (w_pick_oh),
        .o_idx    (w_pick_idx),
        .o_any    (w_pick_any)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state       <= S_IDLE;
            r_pending     <= '0;
            r_served      <= '0;
            r_grant       <= '0;
            r_grant_valid <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_terr        <= 1'b0;
            r_ptr         <= '0;
            r_idx         <= '0;
            r_cnt         <= '0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_pending <= bus.wl_req;
                        r_served  <= '0;
                        r_terr    <= 1'b0;
                        r_busy    <= 1'b1;
                        r_cnt     <= '0;
                        if (w_pick_any) begin
                            r_state       <= S_GRANT;
                            r_grant       <= w_pick_oh;
                            r_idx         <= w_pick_idx;
                            r_grant_valid <= 1'b1;
                        end else begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end
                    end
                end
                S_GRANT: begin
                    if (w_retire) begin
                        r_pending <= w_rem;
                        r_ptr     <= w_next_ptr;
                        r_cnt     <= '0;
                        if (w_ack) begin
                            r_served <= r_served | r_grant;
                        end else begin
                            r_terr <= 1'b1;
                        end
                        if (w_pick_any) begin
                            r_grant <= w_pick_oh;
                            r_idx   <= w_pick_idx;
                        end else begin
                            r_state       <= S_DONE;
                            r_grant       <= '0;
                            r_grant_valid <= 1'b0;
                            r_done        <= 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.grant       = r_grant;
    assign bus.grant_valid = r_grant_valid;
    assign bus.busy        = r_busy;
    assign bus.done        = r_done;
    assign bus.served_mask = r_served;
    assign bus.timeout_err = r_terr;

endmodule

// File: tb/tb_wl_sweep_scheduler.sv
// Directed sweeps with an expected-grant queue for wl_sweep_scheduler.
module tb_wl_sweep_scheduler;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    wl_sweep_scheduler_if #(.N_PORTS(4)) bus ();

    wl_sweep_scheduler #(
        .N_PORTS   (4),
        .TO_W      (8),
        .TO_CYCLES (200)
    ) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    int         total = 0;
    int         bad   = 0;
    logic [3:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Grant must be one-hot exactly when grant_valid, on every cycle out of reset.
    always @(negedge clk) begin
        if (!rst) begin
            total++;
            assert (((bus.grant != 4'b0) === bus.grant_valid) && $onehot0(bus.grant)) else begin
                bad++;
                $error("FAIL grant_onehot: observed grant=%b valid=%b expected onehot iff valid",
                       bus.grant, bus.grant_valid);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed time limit reached expected finish");
        $fatal(1, "watchdog");
    end

    task automatic poke(input bit noise);
        if (noise) begin
            bus.start  = 1'b1;
            bus.wl_req = ~bus.wl_req;
        end
    endtask

    task automatic start_sweep(input logic [3:0] req);
        bus.start  = 1'b1;
        bus.wl_req = req;
        @(negedge clk);
        bus.start = 1'b0;
        check("busy_after_start", 32'(bus.busy), 32'd1);
    endtask

    task automatic run_grants(input logic [3:0] stall, input int ack_dly, input bit noise);
        logic [3:0] e;
        int         n;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("grant_valid", 32'(bus.grant_valid), 32'd1);
            check("grant", 32'(bus.grant), 32'(e));
            if (stall != 4'b0 && bus.grant === stall) begin
                n = 0;
                while (bus.grant === e && n < 400) begin
                    n++;
                    poke(noise);
                    @(negedge clk);
                end
                check("stall_hold", 32'(n), 32'd200);
            end else begin
                for (int k = 0; k < ack_dly; k++) begin
                    poke(noise);
                    @(negedge clk);
                    check("grant_stable", 32'(bus.grant), 32'(e));
                end
                poke(noise);
                bus.grant_ack = 1'b1;
                @(negedge clk);
                bus.grant_ack = 1'b0;
            end
        end
    endtask

    task automatic check_done(input logic [3:0] served, input logic terr);
        check("done_pulse", 32'(bus.done), 32'd1);
        check("done_busy", 32'(bus.busy), 32'd1);
        check("done_gv", 32'(bus.grant_valid), 32'd0);
        check("done_grant", 32'(bus.grant), 32'd0);
        check("served_mask", 32'(bus.served_mask), 32'(served));
        check("timeout_err", 32'(bus.timeout_err), 32'(terr));
        @(negedge clk);
        bus.start = 1'b0;
        check("done_cleared", 32'(bus.done), 32'd0);
        check("idle_busy", 32'(bus.busy), 32'd0);
        check("served_hold", 32'(bus.served_mask), 32'(served));
        @(negedge clk);
        check("idle_gv", 32'(bus.grant_valid), 32'd0);
        check("idle_busy2", 32'(bus.busy), 32'd0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_grant"}, 32'(bus.grant), 32'd0);
        check({tag, "_gv"}, 32'(bus.grant_valid), 32'd0);
        check({tag, "_busy"}, 32'(bus.busy), 32'd0);
        check({tag, "_done"}, 32'(bus.done), 32'd0);
        check({tag, "_served"}, 32'(bus.served_mask), 32'd0);
        check({tag, "_terr"}, 32'(bus.timeout_err), 32'd0);
    endtask

    initial begin
        bus.start     = 1'b0;
        bus.wl_req    = 4'b0;
        bus.grant_ack = 1'b0;
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;
        @(negedge clk);

        // Sweep 1011 with immediate acks, pointer starts at 0.
        exp_q.push_back(4'b0001);
        exp_q.push_back(4'b0010);
        exp_q.push_back(4'b1000);
        start_sweep(4'b1011);
        run_grants(4'b0, 0, 1'b0);
        check_done(4'b1011, 1'b0);

        // Single request at bit 1 leaves the pointer at 2.
        exp_q.push_back(4'b0010);
        start_sweep(4'b0010);
        run_grants(4'b0, 0, 1'b0);
        check_done(4'b0010, 1'b0);

        // Full request from pointer 2.
        exp_q.push_back(4'b0100);
        exp_q.push_back(4'b1000);
        exp_q.push_back(4'b0001);
        exp_q.push_back(4'b0010);
        start_sweep(4'b1111);
        run_grants(4'b0, 0, 1'b0);
        check_done(4'b1111, 1'b0);

        // Empty request: straight to done, no grant.
        start_sweep(4'b0000);
        check_done(4'b0000, 1'b0);

        // Request at bit 0 moves the pointer to 1.
        exp_q.push_back(4'b0001);
        start_sweep(4'b0001);
        run_grants(4'b0, 0, 1'b0);
        check_done(4'b0001, 1'b0);

        // Bit 1 never acked: abandoned after 200 cycles, then bit 2 acked.
        exp_q.push_back(4'b0010);
        exp_q.push_back(4'b0100);
        start_sweep(4'b0110);
        run_grants(4'b0010, 0, 1'b0);
        check_done(4'b0100, 1'b1);

        // Start and wl_req churn during the sweep; delayed acks, pointer at 3.
        exp_q.push_back(4'b1000);
        exp_q.push_back(4'b0001);
        exp_q.push_back(4'b0100);
        start_sweep(4'b1101);
        run_grants(4'b0, 2, 1'b1);
        check_done(4'b1101, 1'b0);

        // Reset mid-grant aborts the sweep and returns the pointer to 0.
        start_sweep(4'b1111);
        check("pre_reset_grant", 32'(bus.grant), 32'b1000);
        rst = 1'b1;
        @(negedge clk);
        check_all_zero("mid_reset");
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("no_done_after_reset", 32'(bus.done), 32'd0);
        end
        exp_q.push_back(4'b0001);
        exp_q.push_back(4'b0010);
        exp_q.push_back(4'b0100);
        exp_q.push_back(4'b1000);
        start_sweep(4'b1111);
        run_grants(4'b0, 0, 1'b0);
        check_done(4'b1111, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
